dsdmnist_batchseq: RTL and testbench
====================================

Name: dsdmnist_batchseq

Overview:
Parametrised batch sequencer for the MNIST pipeline. It replaces the fixed 4-bit loop counter and 12-tap start delay chain in the top level. It detects the start-switch edge, launches image loads with a programmable launch delay, and limits the number of images in flight through layers 1–3 with a credit count. It also tracks completed results and raises the done LED and the ARM interrupt, with an optional acknowledge handshake.

Parameters:
MAXIMG, 1024, largest batch accepted; CW = $clog2(MAXIMG+1) for all counts
STARTDLY, 12, cycles between a trigger and the load-start pulse (must be ≥1)
MAXINFL, 2, maximum images launched whose result is not yet done (must be ≥1)
INTPULSE, 0, 1 = o_ARMINT is a single-cycle pulse; 0 = o_ARMINT is a level held until i_ARMINT_ACK

Ports:
i_CLK  in  1  clock
i_RST  in  1  reset; asynchronous, active-high
i_STARTSW  in  1  start switch, level; only a rising edge starts a batch
i_ABORT  in  1  synchronous abort of the running batch
i_IMGNUM  in  CW  batch size, sampled when a start is accepted
i_LOAD_DONE  in  1  pulse from the image loader: current image has been loaded
i_RESULT_DONE  in  1  pulse from the result writer: one image's result has been written
i_ARMINT_ACK  in  1  interrupt acknowledge (used only when INTPULSE=0)
o_IMGLOAD_START  out  1  single-cycle pulse that starts the loader
o_IMGIDX  out  CW  index of the image being launched; valid while o_IMGLOAD_START=1
o_RESIDX  out  CW  number of results completed in this batch (write address base)
o_BUSY  out  1  high while a batch is active
o_DONELED  out  1  high once the batch is complete
o_ARMINT  out  1  interrupt to the ARM core
o_ERR  out  1  sticky protocol-error flag

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal startsw_z resets to 1, so a switch held high through reset does not start a batch.
  - State = IDLE; all counters 0.
- States: IDLE, DELAY, WAITLOAD, DRAIN, DONE.
- Start accept:
  - Condition: i_STARTSW=1 and startsw_z=0 at a clock edge, while in IDLE or DONE.
  - Action: latch i_IMGNUM; clear launched/results/inflight counters, o_DONELED, o_ERR and o_ARMINT; load the delay counter with STARTDLY-1; go to DELAY; o_BUSY=1 from the next cycle.
  - i_IMGNUM=0: the start is ignored and the state is unchanged.
  - A start edge while BUSY is ignored.
- DELAY:
  - The counter decrements each cycle.
  - When it reaches 0 and inflight<MAXINFL: o_IMGLOAD_START=1 for one cycle, o_IMGIDX=launched, launched+1, inflight+1, go to WAITLOAD.
  - If no credit is available, hold in DELAY at 0 and launch on the first cycle a credit exists.
  - Latency: start edge sampled at edge k → o_IMGLOAD_START high in the cycle after edge k+STARTDLY-1, i.e. STARTDLY cycles later.
- WAITLOAD, on i_LOAD_DONE:
  - If launched<count: reload the delay counter and go to DELAY; the next launch follows the same latency rule.
  - Otherwise go to DRAIN.
- Results:
  - i_RESULT_DONE in any BUSY state: results+1, inflight-1.
  - A launch and a result in the same cycle leave inflight unchanged.
  - o_RESIDX=results.
- Completion:
  - When results reaches count (detected in DRAIN, or in WAITLOAD when count is reached): go to DONE, o_BUSY=0, o_DONELED=1 from the next cycle.
  - o_DONELED holds until the next accepted start or abort.
- Interrupt:
  - INTPULSE=1: o_ARMINT is high for exactly one cycle on entry to DONE.
  - INTPULSE=0: o_ARMINT is set on entry to DONE and cleared in the cycle after i_ARMINT_ACK=1. An ack while o_ARMINT=0 is ignored.
- Protocol errors: all of the following set o_ERR and are otherwise ignored. o_ERR is cleared only by reset or an accepted start.
  - i_LOAD_DONE outside WAITLOAD.
  - i_RESULT_DONE while inflight=0.
  - i_RESULT_DONE outside BUSY.
- Abort:
  - i_ABORT in any state → IDLE next cycle; counters cleared; o_BUSY, o_DONELED and o_ARMINT cleared; no interrupt; o_ERR kept.
  - Abort has priority over a start in the same cycle.
- Reset mid-batch: all state cleared immediately (asynchronous); no interrupt.
- Counters are CW bits wide and never wrap: launched ≤ count ≤ MAXIMG; inflight ≤ MAXINFL.

Test Plan:
- Start timing: STARTDLY=12, MAXINFL=2, i_IMGNUM=3; raise i_STARTSW at edge 10 → o_IMGLOAD_START high in cycle 22 with o_IMGIDX=0; o_BUSY=1 from cycle 11.
- Full batch: loader done 50 cycles after each launch, result done 200 cycles after each load done → exactly 3 launch pulses with o_IMGIDX=0,1,2; the third launch waits for the first result (credit limit); o_DONELED=1 and o_ARMINT=1 the cycle after the 3rd result; o_RESIDX=3.
- Interrupt ack, INTPULSE=0: hold ack low for 5 cycles → o_ARMINT stays high; pulse ack → o_ARMINT low the next cycle, o_DONELED stays 1. Repeat with INTPULSE=1 → o_ARMINT is a 1-cycle pulse.
- Switch and start filtering: i_STARTSW high through reset release → no launch; i_STARTSW retoggled while BUSY → ignored; i_IMGNUM=0 on a start → no launch, o_BUSY stays 0.
- Protocol errors: a spurious i_RESULT_DONE in IDLE → o_ERR=1, counters 0; a launch and a result in the same cycle → inflight unchanged.
- Abort: i_ABORT during the second DELAY → IDLE, no further launch, o_ARMINT stays 0; a fresh start then runs a complete batch normally.

Source files
------------

// File: rtl/dsdmnist_batchseq.sv
`default_nettype none
// ==========================================================================
// dsdmnist_batchseq - MNIST batch sequencer: start-edge detect, delayed image
// launch under an in-flight credit limit, result tracking, LED and interrupt.
// Revision: 1.0
// ==========================================================================
module dsdmnist_batchseq #(
  parameter  int MAXIMG   = 1024,
  parameter  int STARTDLY = 12,
  parameter  int MAXINFL  = 2,
  parameter  int INTPULSE = 0,
  localparam int CW       = $clog2(MAXIMG + 1)
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic          i_STARTSW,
  input  logic          i_ABORT,
  input  logic [CW-1:0] i_IMGNUM,
  input  logic          i_LOAD_DONE,
  input  logic          i_RESULT_DONE,
  input  logic          i_ARMINT_ACK,
  output logic          o_IMGLOAD_START,
  output logic [CW-1:0] o_IMGIDX,
  output logic [CW-1:0] o_RESIDX,
  output logic          o_BUSY,
  output logic          o_DONELED,
  output logic          o_ARMINT,
  output logic          o_ERR
);

  localparam int            DW       = (STARTDLY > 1) ? $clog2(STARTDLY) : 1;
  localparam logic [DW-1:0] DLY_INIT = DW'(STARTDLY - 1);
  localparam logic [CW-1:0] INFL_MAX = CW'(MAXINFL);
  localparam logic [CW-1:0] IMG_MAX  = CW'(MAXIMG);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_WAITLOAD = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          startsw_z_q, startsw_z_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] launched_q, launched_d;
  logic [CW-1:0] results_q, results_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          doneled_q, doneled_d;
  logic          armint_q, armint_d;
  logic          err_q, err_d;

  logic busy, launch, res_ok, start_ok;

  always_comb begin
    busy     = (state_q == S_DELAY) || (state_q == S_WAITLOAD) || (state_q == S_DRAIN);
    launch   = (state_q == S_DELAY) && (dly_q == '0) && (inflight_q < INFL_MAX);
    res_ok   = i_RESULT_DONE && busy && (inflight_q != '0);
    start_ok = i_STARTSW && !startsw_z_q && (i_IMGNUM != '0)
               && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_comb begin
    state_d     = state_q;
    startsw_z_d = i_STARTSW;
    count_d     = count_q;
    launched_d  = launch ? launched_q + CW'(1) : launched_q;
    results_d   = res_ok ? results_q + CW'(1) : results_q;
    inflight_d  = inflight_q;
    dly_d       = dly_q;
    doneled_d   = doneled_q;
    armint_d    = (INTPULSE != 0) ? 1'b0 : (armint_q && !i_ARMINT_ACK);
    err_d       = err_q;

    if (launch && !res_ok) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!launch && res_ok) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (i_LOAD_DONE && (state_q != S_WAITLOAD)) err_d = 1'b1;
    if (i_RESULT_DONE && !res_ok)               err_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          count_d    = (i_IMGNUM > IMG_MAX) ? IMG_MAX : i_IMGNUM;
          launched_d = '0;
          results_d  = '0;
          inflight_d = '0;
          doneled_d  = 1'b0;
          armint_d   = 1'b0;
          err_d      = 1'b0;
          dly_d      = DLY_INIT;
          state_d    = S_DELAY;
        end
      end
      S_DELAY: begin
        // Counter parks at zero until a credit frees up.
        if (dly_q != '0) begin
          dly_d = dly_q - DW'(1);
        end else if (launch) begin
          state_d = S_WAITLOAD;
        end
      end
      S_WAITLOAD: begin
        if (i_LOAD_DONE) begin
          if (launched_q < count_q) begin
            dly_d   = DLY_INIT;
            state_d = S_DELAY;
          end else if (results_d == count_q) begin
            doneled_d = 1'b1;
            armint_d  = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (results_d == count_q) begin
          doneled_d = 1'b1;
          armint_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything except the sticky error flag.
    if (i_ABORT) begin
      state_d    = S_IDLE;
      count_d    = '0;
      launched_d = '0;
      results_d  = '0;
      inflight_d = '0;
      dly_d      = '0;
      doneled_d  = 1'b0;
      armint_d   = 1'b0;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      startsw_z_q <= 1'b1;
      count_q     <= '0;
      launched_q  <= '0;
      results_q   <= '0;
      inflight_q  <= '0;
      dly_q       <= '0;
      doneled_q   <= 1'b0;
      armint_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      startsw_z_q <= startsw_z_d;
      count_q     <= count_d;
      launched_q  <= launched_d;
      results_q   <= results_d;
      inflight_q  <= inflight_d;
      dly_q       <= dly_d;
      doneled_q   <= doneled_d;
      armint_q    <= armint_d;
      err_q       <= err_d;
    end
  end

  assign o_IMGLOAD_START = launch;
  assign o_IMGIDX        = launch ? launched_q : '0;
  assign o_RESIDX        = results_q;
  assign o_BUSY          = busy;
  assign o_DONELED       = doneled_q;
  assign o_ARMINT        = armint_q;
  assign o_ERR           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dsdmnist_batchseq.sv
`default_nettype none
// ==========================================================================
// tb_dsdmnist_batchseq - directed bench; launches checked by a scoreboard.
// Revision: 1.0
// ==========================================================================
module tb_dsdmnist_batchseq;

  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          startsw = 1'b1;
  logic          abort_i = 1'b0;
  logic [CW-1:0] imgnum = 11'd3;
  logic          load_done = 1'b0;
  logic          result_done = 1'b0;
  logic          ack = 1'b0;

  logic          st0, st1, busy0, busy1, led0, led1, int0, int1, err0, err1;
  logic [CW-1:0] idx0, idx1, res0, res1;

  int edge_n = 0;
  int total  = 0;
  int bad    = 0;

  typedef struct {
    int e;
    int idx;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   load_at[$];
  int   res_at[$];

  dsdmnist_batchseq #(.INTPULSE(0)) dut0 (
    .i_CLK(clk), .i_RST(rst), .i_STARTSW(startsw), .i_ABORT(abort_i),
    .i_IMGNUM(imgnum), .i_LOAD_DONE(load_done), .i_RESULT_DONE(result_done),
    .i_ARMINT_ACK(ack), .o_IMGLOAD_START(st0), .o_IMGIDX(idx0), .o_RESIDX(res0),
    .o_BUSY(busy0), .o_DONELED(led0), .o_ARMINT(int0), .o_ERR(err0)
  );

  dsdmnist_batchseq #(.INTPULSE(1)) dut1 (
    .i_CLK(clk), .i_RST(rst), .i_STARTSW(startsw), .i_ABORT(abort_i),
    .i_IMGNUM(imgnum), .i_LOAD_DONE(load_done), .i_RESULT_DONE(result_done),
    .i_ARMINT_ACK(ack), .o_IMGLOAD_START(st1), .o_IMGIDX(idx1), .o_RESIDX(res1),
    .o_BUSY(busy1), .o_DONELED(led1), .o_ARMINT(int1), .o_ERR(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Everything is driven and sampled on the negedge preceding sample edge e.
  task automatic at_edge(input int e);
    while (edge_n != e - 1) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n + 1, got, exp);
    end
  endtask

  task automatic push_launch(input int e, input int idx);
    exp_t x;
    x.e   = e;
    x.idx = idx;
    q0.push_back(x);
    q1.push_back(x);
  endtask

  task automatic scb(input int d, input logic [CW-1:0] idx);
    exp_t x;
    total++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL launch%0d unexpected: got edge %0d idx %0d expected none", d, edge_n + 1, idx);
    end else begin
      x = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (x.e != edge_n + 1 || int'(idx) != x.idx) begin
        bad++;
        $display("FAIL launch%0d: got edge %0d idx %0d expected edge %0d idx %0d",
                 d, edge_n + 1, idx, x.e, x.idx);
      end
    end
  endtask

  // Monitor: every launch pulse is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (st0) scb(0, idx0);
    if (st1) scb(1, idx1);
  end

  // Loader / result-writer pulses from the directed schedule.
  always @(negedge clk) begin
    load_done   = 1'b0;
    result_done = 1'b0;
    foreach (load_at[i]) if (load_at[i] == edge_n + 1) load_done = 1'b1;
    foreach (res_at[i])  if (res_at[i] == edge_n + 1)  result_done = 1'b1;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // batch 1 (start edge 10, 3 images), spurious result at 555,
    // batch 2 aborted, batch 3 (2 images) with result coinciding with launch 642
    load_at = '{72, 134, 323, 580, 630, 650};
    res_at  = '{272, 334, 523, 555, 642, 660};

    at_edge(2);
    chk("reset_out0", {st0, idx0, res0, busy0, led0, int0, err0}, 0);
    chk("reset_out1", {st1, idx1, res1, busy1, led1, int1, err1}, 0);
    at_edge(3);  rst = 1'b0;
    at_edge(8);  startsw = 1'b0;
    at_edge(9);  chk("sw_held_through_reset_busy", busy0, 0);
    at_edge(10);
    chk("busy_before_start", busy0, 0);
    startsw = 1'b1;
    push_launch(22, 0);
    push_launch(84, 1);
    push_launch(273, 2);
    at_edge(11); chk("busy_after_start", busy0, 1);
    at_edge(30); startsw = 1'b0;
    at_edge(40); startsw = 1'b1;
    at_edge(45); chk("retoggle_busy", busy0, 1);

    at_edge(524);
    chk("b1_doneled", led0, 1);
    chk("b1_residx", res0, 3);
    chk("b1_busy", busy0, 0);
    chk("b1_armint_level", int0, 1);
    chk("b1_armint_pulse", int1, 1);
    at_edge(525); chk("pulse_cleared", int1, 0);
    at_edge(526); chk("level_held_526", int0, 1);
    at_edge(528); chk("level_held_528", int0, 1);
    at_edge(529); ack = 1'b1;
    at_edge(530);
    ack = 1'b0;
    chk("ack_clears_int", int0, 0);
    chk("ack_keeps_led", led0, 1);

    at_edge(535); startsw = 1'b0;
    at_edge(540); imgnum = 11'd0; startsw = 1'b1;
    at_edge(542);
    chk("imgnum0_busy", busy0, 0);
    chk("imgnum0_led", led0, 1);
    at_edge(545); startsw = 1'b0; imgnum = 11'd3;
    at_edge(549); chk("no_err_b1", err0, 0);
    at_edge(550); abort_i = 1'b1;
    at_edge(551);
    abort_i = 1'b0;
    chk("abort_done_led", led0, 0);
    at_edge(556);
    chk("spurious_err", err0, 1);
    chk("spurious_residx", res0, 0);

    at_edge(560); startsw = 1'b1; push_launch(572, 0);
    at_edge(561);
    chk("start_clears_err", err0, 0);
    chk("b2_busy", busy1, 1);
    at_edge(570); startsw = 1'b0;
    at_edge(585); abort_i = 1'b1;
    at_edge(586);
    abort_i = 1'b0;
    chk("abort_busy", busy0, 0);
    at_edge(600);
    chk("abort_no_int0", int0, 0);
    chk("abort_no_int1", int1, 0);
    chk("abort_no_led", led0, 0);
    imgnum = 11'd2;

    at_edge(610); startsw = 1'b1; push_launch(622, 0); push_launch(642, 1);
    at_edge(620); startsw = 1'b0;
    at_edge(661);
    chk("b3_doneled", led0, 1);
    chk("b3_residx", res0, 2);
    chk("b3_int_level", int0, 1);
    chk("b3_int_pulse", int1, 1);
    chk("b3_no_err", err0, 0);
    chk("b3_busy", busy0, 0);

    at_edge(670);
    chk("pending_launch0", q0.size(), 0);
    chk("pending_launch1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
